ddr3_port_arbiter: RTL and testbench

DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

---
 rtl/ddr3_port_arbiter_if.sv | 49 ++++
 rtl/ddr3_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_port_arbiter_if.sv
// Signal bundle between the host ports, the DDR3 port arbiter and the
// command-processing logic behind it.
interface ddr3_port_arbiter_if #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned AW     = 26,
    parameter int unsigned DW     = 16
);
    localparam int unsigned TW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic                      initdone;
    logic [NPORTS-1:0][2:0]    port_cmd;
    logic [NPORTS-1:0][AW-1:0] port_addr;
    logic [NPORTS-1:0][1:0]    port_sz;
    logic [NPORTS-1:0][2:0]    port_op;
    logic [NPORTS-1:0][DW-1:0] port_din;
    logic [NPORTS-1:0]         port_notfull;
    logic [NPORTS-1:0]         port_read;
    logic [NPORTS-1:0]         port_validout;
    logic [NPORTS-1:0][DW-1:0] port_dout;
    logic [NPORTS-1:0][AW-1:0] port_raddr;

    logic                      mc_valid;
    logic [2:0]                mc_cmd;
    logic [AW-1:0]             mc_addr;
    logic [1:0]                mc_sz;
    logic [2:0]                mc_op;
    logic [DW-1:0]             mc_wdata;
    logic [TW-1:0]             mc_tag;
    logic                      mc_get;
    logic                      mc_rvalid;
    logic [TW-1:0]             mc_rtag;
    logic [AW-1:0]             mc_raddr;
    logic [DW-1:0]             mc_rdata;
    logic                      err;

    modport master (
        output initdone, port_cmd, port_addr, port_sz, port_op, port_din, port_read,
               mc_get, mc_rvalid, mc_rtag, mc_raddr, mc_rdata,
        input  port_notfull, port_validout, port_dout, port_raddr,
               mc_valid, mc_cmd, mc_addr, mc_sz, mc_op, mc_wdata, mc_tag, err
    );

    modport slave (
        input  initdone, port_cmd, port_addr, port_sz, port_op, port_din, port_read,
               mc_get, mc_rvalid, mc_rtag, mc_raddr, mc_rdata,
        output port_notfull, port_validout, port_dout, port_raddr,
               mc_valid, mc_cmd, mc_addr, mc_sz, mc_op, mc_wdata, mc_tag, err
    );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter feeding per-port request FIFOs into a single DDR3 command
// slot, with per-port read-return FIFOs and outstanding-read flow control.
module ddr3_port_arbiter #(
    parameter int unsigned NPORTS   = 4,
    parameter int unsigned AW       = 26,
    parameter int unsigned DW       = 16,
    parameter int unsigned DEPTH_P2 = 4
) (
    input logic                clk,
    input logic                reset,
    ddr3_port_arbiter_if.slave bus
);
    localparam int unsigned TW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned D  = 1 << DEPTH_P2;
    localparam int unsigned PW = DEPTH_P2 + 1;
    localparam int unsigned AI = DEPTH_P2;
    localparam logic [2:0] SCR = 3'b001;
    localparam logic [2:0] SCW = 3'b010;

    typedef struct packed {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [1:0]    sz;
        logic [2:0]    op;
        logic [DW-1:0] din;
    } req_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ret_t;

    req_t          req_mem [NPORTS][D];
    ret_t          ret_mem [NPORTS][D];
    logic [PW-1:0] req_wp  [NPORTS];
    logic [PW-1:0] req_rp  [NPORTS];
    logic [PW-1:0] ret_wp  [NPORTS];
    logic [PW-1:0] ret_rp  [NPORTS];
    logic [PW-1:0] oc      [NPORTS];
    logic [TW-1:0] last_grant;
    logic          mc_valid_q;
    req_t          mc_q;
    logic [TW-1:0] mc_tag_q;
    logic          err_q;

    logic [NPORTS-1:0] req_full, req_empty, req_push, req_pop;
    logic [NPORTS-1:0] ret_empty, ret_push, ret_pop, eligible, rd_grant;
    req_t              req_head [NPORTS];
    logic [PW-1:0]     ret_fill [NPORTS];
    logic              slot_free, grant_any, ret_bad;
    logic [TW-1:0]     grant_idx;
    req_t              grant_req;

    // FIFO status, push/pop qualification and per-port eligibility
    always_comb begin : port_status
        for (int p = 0; p < NPORTS; p++) begin
            req_full[p]  = (req_wp[p][PW-1] != req_rp[p][PW-1]) &&
                           (req_wp[p][AI-1:0] == req_rp[p][AI-1:0]);
            req_empty[p] = req_wp[p] == req_rp[p];
            req_head[p]  = req_mem[p][req_rp[p][AI-1:0]];
            req_push[p]  = !req_full[p] && (bus.port_cmd[p] == SCR || bus.port_cmd[p] == SCW);
            ret_empty[p] = ret_wp[p] == ret_rp[p];
            ret_fill[p]  = ret_wp[p] - ret_rp[p];
            ret_pop[p]   = bus.port_read[p] && !ret_empty[p];
            ret_push[p]  = bus.mc_rvalid && (bus.mc_rtag == TW'(p)) && (oc[p] != '0);
            // A read may only issue if its return data is guaranteed a slot
            eligible[p]  = !req_empty[p] && bus.initdone &&
                           (req_head[p].cmd == SCW ||
                            (req_head[p].cmd == SCR &&
                             ((PW+1)'(oc[p]) + (PW+1)'(ret_fill[p]) < (PW+1)'(D))));
        end
        ret_bad = bus.mc_rvalid && (ret_push == '0);
    end

    // Round-robin search starting after the last granted port
    always_comb begin : arbitrate
        int unsigned k;
        slot_free = !mc_valid_q || bus.mc_get;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_req = '0;
        req_pop   = '0;
        rd_grant  = '0;
        k         = 0;
        for (int unsigned i = 1; i <= NPORTS; i++) begin
            k = (32'(last_grant) + i) % NPORTS;
            if (!grant_any && eligible[k]) begin
                grant_any = 1'b1;
                grant_idx = TW'(k);
                grant_req = req_head[k];
            end
        end
        if (slot_free && grant_any) begin
            req_pop[grant_idx]  = 1'b1;
            rd_grant[grant_idx] = grant_req.cmd == SCR;
        end
    end

    always_ff @(posedge clk) begin : fifo_store
        for (int p = 0; p < NPORTS; p++) begin
            if (req_push[p])
                req_mem[p][req_wp[p][AI-1:0]] <= {bus.port_cmd[p], bus.port_addr[p],
                                                  bus.port_sz[p], bus.port_op[p], bus.port_din[p]};
            if (ret_push[p])
                ret_mem[p][ret_wp[p][AI-1:0]] <= {bus.mc_raddr, bus.mc_rdata};
        end
    end

    always_ff @(posedge clk) begin : fifo_ptrs
        for (int p = 0; p < NPORTS; p++) begin
            if (reset) begin
                req_wp[p] <= '0;
                req_rp[p] <= '0;
                ret_wp[p] <= '0;
                ret_rp[p] <= '0;
                oc[p]     <= '0;
            end else begin
                if (req_push[p]) req_wp[p] <= req_wp[p] + PW'(1);
                if (req_pop[p])  req_rp[p] <= req_rp[p] + PW'(1);
                if (ret_push[p]) ret_wp[p] <= ret_wp[p] + PW'(1);
                if (ret_pop[p])  ret_rp[p] <= ret_rp[p] + PW'(1);
                if (rd_grant[p] && !ret_push[p])
                    oc[p] <= oc[p] + PW'(1);
                else if (ret_push[p] && !rd_grant[p])
                    oc[p] <= oc[p] - PW'(1);
            end
        end
    end

    // Issue slot: load on grant, hold while stalled, clear when idle
    always_ff @(posedge clk) begin : issue_slot
        if (reset) begin
            mc_valid_q <= 1'b0;
            mc_q       <= '0;
            mc_tag_q   <= '0;
            last_grant <= TW'(NPORTS - 1);
            err_q      <= 1'b0;
        end else begin
            if (slot_free) begin
                mc_valid_q <= grant_any;
                if (grant_any) begin
                    mc_q       <= grant_req;
                    mc_tag_q   <= grant_idx;
                    last_grant <= grant_idx;
                end
            end
            if (ret_bad) err_q <= 1'b1;
        end
    end

    always_comb begin : port_outputs
        for (int p = 0; p < NPORTS; p++) begin
            bus.port_notfull[p]  = !req_full[p];
            bus.port_validout[p] = !ret_empty[p];
            bus.port_dout[p]     = ret_mem[p][ret_rp[p][AI-1:0]].data;
            bus.port_raddr[p]    = ret_mem[p][ret_rp[p][AI-1:0]].addr;
        end
    end

    assign bus.mc_valid = mc_valid_q;
    assign bus.mc_cmd   = mc_q.cmd;
    assign bus.mc_addr  = mc_q.addr;
    assign bus.mc_sz    = mc_q.sz;
    assign bus.mc_op    = mc_q.op;
    assign bus.mc_wdata = mc_q.din;
    assign bus.mc_tag   = mc_tag_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Scoreboard bench for ddr3_port_arbiter: issued commands and read returns are
// matched against per-port expectation queues filled when stimulus is driven.
module tb_ddr3_port_arbiter;
    localparam int unsigned NPORTS   = 4;
    localparam int unsigned AW       = 26;
    localparam int unsigned DW       = 16;
    localparam int unsigned DEPTH_P2 = 2;
    localparam int unsigned RW       = 3 + AW + 2 + 3 + DW;
    localparam logic [2:0] SCR = 3'b001;
    localparam logic [2:0] SCW = 3'b010;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [RW-1:0]    exp_q [NPORTS][$];
    logic [AW+DW-1:0] ret_q [NPORTS][$];
    int               issue_tag [$];
    int               issue_cyc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr3_port_arbiter_if #(.NPORTS(NPORTS), .AW(AW), .DW(DW)) bus ();

    ddr3_port_arbiter #(.NPORTS(NPORTS), .AW(AW), .DW(DW), .DEPTH_P2(DEPTH_P2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] req_word(input logic [2:0] cmd, input logic [AW-1:0] addr,
                                               input logic [DW-1:0] din);
        return {cmd, addr, addr[1:0], din[2:0], din};
    endfunction

    // Monitor: every consumed command is matched against its port's queue
    always @(negedge clk) begin
        if (!reset && bus.mc_valid && bus.mc_get) begin : mon
            int t;
            logic [RW-1:0] e;
            t = int'(bus.mc_tag);
            issue_tag.push_back(t);
            issue_cyc.push_back(cyc);
            if (exp_q[t].size() == 0)
                check("issue_unexpected_tag", 64'(bus.mc_tag), 64'hff);
            else begin
                e = exp_q[t].pop_front();
                check("issue_fields",
                      64'({bus.mc_cmd, bus.mc_addr, bus.mc_sz, bus.mc_op, bus.mc_wdata}), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.port_cmd  = '0;
        bus.port_addr = '0;
        bus.port_sz   = '0;
        bus.port_op   = '0;
        bus.port_din  = '0;
        bus.port_read = '0;
        bus.mc_rvalid = 1'b0;
        bus.mc_rtag   = '0;
        bus.mc_raddr  = '0;
        bus.mc_rdata  = '0;
    endtask

    task automatic drive_req(input int p, input logic [2:0] cmd, input logic [AW-1:0] addr,
                             input logic [DW-1:0] din);
        bus.port_cmd[p]  = cmd;
        bus.port_addr[p] = addr;
        bus.port_sz[p]   = addr[1:0];
        bus.port_op[p]   = din[2:0];
        bus.port_din[p]  = din;
        exp_q[p].push_back(req_word(cmd, addr, din));
    endtask

    task automatic push_one(input int p, input logic [2:0] cmd, input logic [AW-1:0] addr,
                            input logic [DW-1:0] din);
        int n = 0;
        while (!bus.port_notfull[p] && n < 50) begin
            tick();
            n++;
        end
        if (!bus.port_notfull[p])
            check("notfull_wait", 64'(bus.port_notfull[p]), 64'd1);
        else begin
            drive_req(p, cmd, addr, din);
            tick();
            bus.port_cmd[p] = 3'b000;
        end
    endtask

    task automatic send_return(input int tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input bit legal);
        bus.mc_rvalid = 1'b1;
        bus.mc_rtag   = 2'(tag);
        bus.mc_raddr  = addr;
        bus.mc_rdata  = data;
        if (legal) ret_q[tag].push_back({addr, data});
        tick();
        bus.mc_rvalid = 1'b0;
    endtask

    task automatic read_port(input int p);
        logic [AW+DW-1:0] e;
        check("rd_validout", 64'(bus.port_validout[p]), 64'd1);
        if (ret_q[p].size() == 0)
            check("rd_unexpected", 64'(bus.port_validout[p]), 64'd0);
        else begin
            e = ret_q[p].pop_front();
            check("rd_data", 64'({bus.port_raddr[p], bus.port_dout[p]}), 64'(e));
        end
        bus.port_read[p] = 1'b1;
        tick();
        bus.port_read[p] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        bus.initdone = 1'b1;
        bus.mc_get   = 1'b1;
        tick();
        tick();
        for (int p = 0; p < NPORTS; p++) begin
            exp_q[p].delete();
            ret_q[p].delete();
        end
        issue_tag.delete();
        issue_cyc.delete();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        logic [RW-1:0] hold;

        idle_inputs();
        bus.initdone = 1'b1;
        bus.mc_get   = 1'b1;
        tick();
        tick();
        check("rst_mc_valid", 64'(bus.mc_valid), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_validout", 64'(bus.port_validout), 64'd0);
        check("rst_notfull", 64'(bus.port_notfull), 64'hf);
        check("rst_mc_data", 64'({bus.mc_cmd, bus.mc_addr, bus.mc_wdata, bus.mc_tag}), 64'd0);
        reset = 1'b0;

        // Four simultaneous writes: round-robin from port 0, 2-cycle latency
        tick();
        k0 = cyc;
        for (int p = 0; p < 4; p++) drive_req(p, SCW, 26'(16 * p + 1), 16'(16'h1000 + p));
        tick();
        idle_inputs();
        repeat (6) tick();
        check("rr_count", 64'(issue_tag.size()), 64'd4);
        for (int i = 0; i < issue_tag.size(); i++) begin
            check("rr_tag", 64'(issue_tag[i]), 64'(i));
            check("rr_cycle", 64'(issue_cyc[i] - k0), 64'(2 + i));
        end
        check("rr_idle_valid", 64'(bus.mc_valid), 64'd0);

        // Requests held off by initdone, then drained in order
        do_reset();
        bus.initdone = 1'b0;
        for (int i = 0; i < 4; i++) push_one(1, SCW, 26'(32'h100 + i), 16'(16'h2000 + i));
        repeat (4) tick();
        check("init_hold_count", 64'(issue_tag.size()), 64'd0);
        check("init_hold_valid", 64'(bus.mc_valid), 64'd0);
        check("init_full", 64'(bus.port_notfull[1]), 64'd0);
        bus.initdone = 1'b1;
        push_one(1, SCW, 26'h104, 16'h2004);
        repeat (10) tick();
        check("init_count", 64'(issue_tag.size()), 64'd5);
        for (int i = 0; i < issue_tag.size(); i++) check("init_tag", 64'(issue_tag[i]), 64'd1);

        // Outstanding-read limit on port 2
        do_reset();
        for (int i = 0; i < 6; i++) push_one(2, SCR, 26'(32'h200 + i), 16'(16'h3000 + i));
        repeat (6) tick();
        check("oc_limit_count", 64'(issue_tag.size()), 64'd4);
        check("oc_limit_notfull", 64'(bus.port_notfull[2]), 64'd1);
        push_one(2, SCR, 26'h206, 16'h3006);
        push_one(2, SCR, 26'h207, 16'h3007);
        repeat (2) tick();
        check("oc_full_notfull", 64'(bus.port_notfull[2]), 64'd0);
        send_return(2, 26'h200, 16'hbeef, 1'b1);
        repeat (3) tick();
        check("oc_rfill_block", 64'(issue_tag.size()), 64'd4);
        read_port(2);
        repeat (4) tick();
        check("oc_release_count", 64'(issue_tag.size()), 64'd5);
        check("oc_ret_empty", 64'(bus.port_validout[2]), 64'd0);

        // Read grant and read return on port 0 in the same cycle
        do_reset();
        push_one(0, SCR, 26'h10, 16'h0);
        repeat (3) tick();
        k0 = cyc;
        drive_req(0, SCR, 26'h11, 16'h1);
        tick();
        bus.port_cmd[0] = 3'b000;
        send_return(0, 26'h11, 16'ha5a5, 1'b1);
        check("same_validout", 64'(bus.port_validout[0]), 64'd1);
        check("same_dout", 64'(bus.port_dout[0]), 64'ha5a5);
        tick();
        check("same_count", 64'(issue_tag.size()), 64'd2);
        if (issue_tag.size() >= 2) check("same_grant_cycle", 64'(issue_cyc[1] - k0), 64'd2);
        for (int i = 0; i < 3; i++) push_one(0, SCR, 26'(32'h12 + i), 16'(16'h2 + i));
        repeat (8) tick();
        check("same_oc_count", 64'(issue_tag.size()), 64'd4);
        read_port(0);
        repeat (4) tick();
        check("same_release_count", 64'(issue_tag.size()), 64'd5);

        // Stalled issue slot holds its command and pops nothing
        do_reset();
        bus.mc_get = 1'b0;
        push_one(3, SCW, 26'h300, 16'h4000);
        push_one(3, SCW, 26'h301, 16'h4001);
        push_one(3, SCW, 26'h302, 16'h4002);
        hold = req_word(SCW, 26'h300, 16'h4000);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 64'(bus.mc_valid), 64'd1);
            check("stall_fields",
                  64'({bus.mc_cmd, bus.mc_addr, bus.mc_sz, bus.mc_op, bus.mc_wdata}), 64'(hold));
            check("stall_tag", 64'(bus.mc_tag), 64'd3);
            tick();
        end
        bus.mc_get = 1'b1;
        repeat (6) tick();
        check("stall_drain_count", 64'(issue_tag.size()), 64'd3);

        // Unsolicited return sets sticky err
        do_reset();
        send_return(3, 26'h3ff, 16'h5555, 1'b0);
        check("err_set", 64'(bus.err), 64'd1);
        check("err_no_data", 64'(bus.port_validout[3]), 64'd0);
        repeat (5) tick();
        check("err_sticky", 64'(bus.err), 64'd1);
        do_reset();
        check("err_cleared", 64'(bus.err), 64'd0);
        push_one(1, SCR, 26'h40, 16'h0);
        repeat (3) tick();
        check("pre_reset_err", 64'(bus.err), 64'd0);
        do_reset();
        send_return(1, 26'h40, 16'h7777, 1'b0);
        check("post_reset_err", 64'(bus.err), 64'd1);
        check("post_reset_no_data", 64'(bus.port_validout[1]), 64'd0);

        for (int p = 0; p < NPORTS; p++) check("ret_q_drained", 64'(ret_q[p].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
